grb_pixel_serializer: RTL and testbench

//  Sits between the red/green/blue board memories and the WS2812B line driver.
//  On each controller load strobe it captures one pixel's 8-bit R/G/B data.
//  It applies a global brightness scale and packs the result in WS2812B GRB order.
//  It then presents the 24 bits MSB-first, advancing one bit per driver shift request.

---
 rtl/grb_pixel_serializer.sv | 144 ++++++++++++++
 tb/tb_grb_pixel_serializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/grb_pixel_serializer.sv
// WS2812B pixel serializer: captures R/G/B, applies global brightness, shifts out GRB MSB-first.
// Optional GAMMA_EN macro adds a per-channel gamma ROM stage (load->valid latency 3 instead of 2).
module grb_pixel_serializer #(
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned BRIGHT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic               shift,
  input  logic               clear_err,
  output logic               serial_out,
  output logic               valid,
  output logic [4:0]         bits_left,
  output logic               overrun,
  output logic               underrun
);

  localparam int unsigned NBITS = 3 * COLOR_W;
  localparam int unsigned PROD_W = COLOR_W + BRIGHT_W;

  // c' = (c * (brightness + 1)) >> BRIGHT_W, so full scale passes c unchanged and 0 blanks.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0]  c,
                                                input logic [BRIGHT_W-1:0] b);
    logic [BRIGHT_W:0]   mult;
    logic [PROD_W-1:0]   prod;
    mult = {1'b0, b} + {{BRIGHT_W{1'b0}}, 1'b1};
    prod = {{BRIGHT_W{1'b0}}, c} * {{(COLOR_W-1){1'b0}}, mult};
    scale = COLOR_W'(prod >> BRIGHT_W);
  endfunction

  // S1 capture
  logic [COLOR_W-1:0]  s1_r, s1_g, s1_b;
  logic [BRIGHT_W-1:0] s1_bright;
  logic                s1_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_bright <= '0;
      s1_vld    <= 1'b0;
    end else begin
      s1_vld <= load;
      if (load) begin
        s1_r      <= red_in;
        s1_g      <= green_in;
        s1_b      <= blue_in;
        s1_bright <= brightness;
      end
    end
  end

  logic             wr_vld;
  logic [NBITS-1:0] wr_pix;

`ifdef GAMMA_EN
  // S2 registers the scaled channels; the gamma lookup feeds the shift register.
  logic [COLOR_W-1:0] s2_r, s2_g, s2_b;
  logic               s2_vld;
  logic [COLOR_W-1:0] gamma_rom [2**COLOR_W];

  initial begin
    for (int i = 0; i < 2**COLOR_W; i++) begin
      gamma_rom[i] = COLOR_W'($rtoi($pow(real'(i) / real'(2**COLOR_W - 1), 2.2)
                                    * real'(2**COLOR_W - 1) + 0.5));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_r   <= '0;
      s2_g   <= '0;
      s2_b   <= '0;
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_r <= scale(s1_r, s1_bright);
        s2_g <= scale(s1_g, s1_bright);
        s2_b <= scale(s1_b, s1_bright);
      end
    end
  end

  always_comb begin
    wr_vld = s2_vld;
    wr_pix = {gamma_rom[s2_g], gamma_rom[s2_r], gamma_rom[s2_b]};
  end
`else
  always_comb begin
    wr_vld = s1_vld;
    wr_pix = {scale(s1_g, s1_bright), scale(s1_r, s1_bright), scale(s1_b, s1_bright)};
  end
`endif

  logic [NBITS-1:0] sreg;
  logic             ov_set;
  logic             ur_set;

  // A shift coinciding with a write only forgives the final bit (bits_left == 1).
  always_comb begin
    ov_set = wr_vld && (shift ? (bits_left > 5'd1) : (bits_left != 5'd0));
    ur_set = shift && !wr_vld && (bits_left == 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bits_left <= '0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (wr_vld) begin
        sreg      <= wr_pix;
        bits_left <= 5'(NBITS);
      end else if (shift && bits_left != 5'd0) begin
        sreg      <= {sreg[NBITS-2:0], 1'b0};
        bits_left <= bits_left - 5'd1;
      end

      if (ov_set) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end

      if (ur_set) begin
        underrun <= 1'b1;
      end else if (clear_err) begin
        underrun <= 1'b0;
      end
    end
  end

  assign serial_out = sreg[NBITS-1];
  assign valid      = (bits_left != 5'd0);

endmodule

// File: tb/tb_grb_pixel_serializer.sv
// Directed self-checking bench for grb_pixel_serializer (default build, latency 2).
module tb_grb_pixel_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] red_in, green_in, blue_in, brightness;
  logic       shift;
  logic       clear_err;
  logic       serial_out;
  logic       valid;
  logic [4:0] bits_left;
  logic       overrun;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  logic [23:0] stream;
  int          vcount;

  always #5 clk = ~clk;

  grb_pixel_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .brightness (brightness),
    .shift      (shift),
    .clear_err  (clear_err),
    .serial_out (serial_out),
    .valid      (valid),
    .bits_left  (bits_left),
    .overrun    (overrun),
    .underrun   (underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load strobe for one cycle; checks the 2-cycle latency on the way.
  task automatic load_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] br, input string tag);
    @(negedge clk);
    red_in = r; green_in = g; blue_in = b; brightness = br; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check({tag, "_bits24"}, 32'(bits_left), 32'd24);
    check({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  // Shift n bits, collecting serial_out (MSB-first) and counting valid cycles.
  task automatic shift_n(input int n, output logic [23:0] s, output int vc);
    s  = '0;
    vc = 0;
    for (int i = 0; i < n; i++) begin
      s = {s[22:0], serial_out};
      if (valid) vc++;
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; shift = 1'b0; clear_err = 1'b0;
    red_in = '0; green_in = '0; blue_in = '0; brightness = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // 1. idle after reset
    check("rst_serial", 32'(serial_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_bits", 32'(bits_left), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_udr", 32'(underrun), 32'd0);

    // latency: one cycle after the strobe nothing is visible yet
    @(negedge clk);
    red_in = 8'h12; green_in = 8'hAB; blue_in = 8'h34; brightness = 8'hFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("lat_n1_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("lat_n2_bits", 32'(bits_left), 32'd24);
    check("lat_n2_serial", 32'(serial_out), 32'd1);

    // 2. full-scale pixel, GRB order
    shift_n(24, stream, vcount);
    check("full_stream", 32'(stream), 32'hAB1234);
    check("full_vcount", 32'(vcount), 32'd24);
    check("full_valid_end", 32'(valid), 32'd0);
    check("full_bits_end", 32'(bits_left), 32'd0);
    check("full_ovr", 32'(overrun), 32'd0);

    // 3. brightness scaling
    load_pixel(8'hFF, 8'hFF, 8'hFF, 8'h7F, "half");
    shift_n(24, stream, vcount);
    check("half_stream", 32'(stream), 32'h7F7F7F);

    load_pixel(8'hFF, 8'hFF, 8'hFF, 8'h00, "off");
    shift_n(24, stream, vcount);
    check("off_stream", 32'(stream), 32'h000000);
    check("off_vcount", 32'(vcount), 32'd24);

    // 0x80*64>>8=0x20, 0x40->0x10, 0xC8->0x32; GRB = 10 20 32
    load_pixel(8'h80, 8'h40, 8'hC8, 8'h3F, "quart");
    shift_n(24, stream, vcount);
    check("quart_stream", 32'(stream), 32'h102032);

    // 4. overrun: new pixel mid-stream
    load_pixel(8'h12, 8'hAB, 8'h34, 8'hFF, "pa");
    shift_n(10, stream, vcount);
    check("pa_bits14", 32'(bits_left), 32'd14);
    load_pixel(8'h01, 8'hC0, 8'h02, 8'hFF, "pb");
    check("pb_ovr", 32'(overrun), 32'd1);
    check("pb_serial", 32'(serial_out), 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("pb_clr_ovr", 32'(overrun), 32'd0);
    shift_n(24, stream, vcount);
    check("pb_stream", 32'(stream), 32'hC00102);

    // last bit shifted in the same cycle as the write: not an overrun
    load_pixel(8'h00, 8'hFF, 8'h00, 8'hFF, "pc");
    shift_n(23, stream, vcount);
    check("pc_bits1", 32'(bits_left), 32'd1);
    @(negedge clk);
    red_in = 8'h00; green_in = 8'h0F; blue_in = 8'h00; brightness = 8'hFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0; shift = 1'b1;
    @(negedge clk);
    shift = 1'b0;
    check("pc_edge_ovr", 32'(overrun), 32'd0);
    check("pc_edge_bits", 32'(bits_left), 32'd24);
    check("pc_edge_serial", 32'(serial_out), 32'd0);

    // write with one bit pending and no shift: overrun
    shift_n(23, stream, vcount);
    check("pd_stream_hi", 32'(stream[22:15]), 32'h0F);
    load_pixel(8'h00, 8'h00, 8'h00, 8'hFF, "pd");
    check("pd_ovr", 32'(overrun), 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("pd_clr_ovr", 32'(overrun), 32'd0);
    shift_n(24, stream, vcount);

    // 5. underrun
    check("ur_pre_bits", 32'(bits_left), 32'd0);
    shift_n(1, stream, vcount);
    check("ur_flag", 32'(underrun), 32'd1);
    check("ur_bits", 32'(bits_left), 32'd0);
    check("ur_ovr", 32'(overrun), 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("ur_clr", 32'(underrun), 32'd0);

    // reset mid-pixel with overrun pending
    load_pixel(8'hFF, 8'hFF, 8'hFF, 8'hFF, "pe");
    load_pixel(8'hFF, 8'hFF, 8'hFF, 8'hFF, "pf");
    shift_n(5, stream, vcount);
    check("pf_ovr", 32'(overrun), 32'd1);
    check("pf_serial", 32'(serial_out), 32'd1);
    check("pf_bits", 32'(bits_left), 32'd19);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_serial", 32'(serial_out), 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_bits", 32'(bits_left), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);
    check("mrst_udr", 32'(underrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_valid", 32'(valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
